// File: rtl/register_file_pkg.sv
// Shared constants and the operand-result bundle for the architectural register file.
// Holds no logic.
// Used by register_file and register_read_port.
package register_file_pkg;

    localparam int ROB_WIDTH      = 4;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_COUNT      = 32;
    localparam int DATA_WIDTH     = 32;

    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

    // Resolved operand: either a usable value, or the ROB tag still owed.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] value;
        logic [ROB_WIDTH-1:0]  tag;
    } operand_t;

endpackage

// File: rtl/register_file_read_port.sv
// Resolves one source operand from storage, the same-cycle commit bypass or the ROB.
// Latency: purely combinational, zero cycles.
// Backpressure: none; an unresolved operand is reported as valid=0 with its producer tag.
module register_read_port
    import register_file_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic                      reg_busy,
    input  logic [ROB_WIDTH-1:0]      reg_tag,
    input  logic [DATA_WIDTH-1:0]     reg_value,
    input  logic                      commit_valid,
    input  logic [REG_ADDR_WIDTH-1:0] commit_dest,
    input  logic [ROB_WIDTH-1:0]      commit_rob_id,
    input  logic [DATA_WIDTH-1:0]     commit_value,
    input  logic                      rob_ready,
    input  logic [DATA_WIDTH-1:0]     rob_value,
    output logic [ROB_WIDTH-1:0]      dep,
    output operand_t                  result
);

    // Priority: x0, architectural value, commit bypass, ROB result, else wait on tag.
    always_comb begin
        dep          = reg_busy ? reg_tag : '0;
        result.valid = 1'b1;
        result.value = '0;
        result.tag   = '0;
        if (rs == ZERO_REG) begin
            result.value = '0;
        end else if (!reg_busy) begin
            result.value = reg_value;
        end else if (commit_valid && (commit_dest == rs) && (commit_rob_id == reg_tag)) begin
            result.value = commit_value;
        end else if (rob_ready) begin
            result.value = rob_value;
        end else begin
            result.valid = 1'b0;
            result.tag   = reg_tag;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and ROB rename tag.
// Latency: reads combinational; commit/rename/clear visible the cycle after the edge.
// Backpressure: none; every commit and rename presented is accepted in that cycle.
module register_file
    import register_file_pkg::*;
(
    input  logic                      clockIn,
    input  logic                      resetIn,
    input  logic                      clear,
    input  logic                      regUpdateValid,
    input  logic [REG_ADDR_WIDTH-1:0] regUpdateDest,
    input  logic [DATA_WIDTH-1:0]     regValue,
    input  logic [ROB_WIDTH-1:0]      regUpdateRobId,
    output logic [ROB_WIDTH-1:0]      rs1Dep,
    input  logic                      rs1Ready,
    input  logic [DATA_WIDTH-1:0]     rs1Value,
    output logic [ROB_WIDTH-1:0]      rs2Dep,
    input  logic                      rs2Ready,
    input  logic [DATA_WIDTH-1:0]     rs2Value,
    input  logic [REG_ADDR_WIDTH-1:0] iuRs1,
    input  logic [REG_ADDR_WIDTH-1:0] iuRs2,
    output logic                      iuRs1Valid,
    output logic [DATA_WIDTH-1:0]     iuRs1Value,
    output logic [ROB_WIDTH-1:0]      iuRs1Tag,
    output logic                      iuRs2Valid,
    output logic [DATA_WIDTH-1:0]     iuRs2Value,
    output logic [ROB_WIDTH-1:0]      iuRs2Tag,
    input  logic                      renameValid,
    input  logic [REG_ADDR_WIDTH-1:0] renameDest,
    input  logic [ROB_WIDTH-1:0]      renameRobId
);

    logic [DATA_WIDTH-1:0] values [REG_COUNT];
    logic [ROB_WIDTH-1:0]  tags   [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;

    operand_t op1;
    operand_t op2;

    // Commit, then rename (which wins on busy/tag), then flush (which wins over both);
    // the commit value is written in every case.
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            busy <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                values[i] <= '0;
                tags[i]   <= '0;
            end
        end else begin
            if (regUpdateValid && (regUpdateDest != ZERO_REG)) begin
                values[regUpdateDest] <= regValue;
                // Only the newest producer may release the register.
                if (busy[regUpdateDest] && (tags[regUpdateDest] == regUpdateRobId)) begin
                    busy[regUpdateDest] <= 1'b0;
                end
            end
            if (clear) begin
                busy <= '0;
                for (int i = 0; i < REG_COUNT; i++) begin
                    tags[i] <= '0;
                end
            end else if (renameValid && (renameDest != ZERO_REG)) begin
                busy[renameDest] <= 1'b1;
                tags[renameDest] <= renameRobId;
            end
        end
    end

    register_read_port u_read1 (
        .rs            (iuRs1),
        .reg_busy      (busy[iuRs1]),
        .reg_tag       (tags[iuRs1]),
        .reg_value     (values[iuRs1]),
        .commit_valid  (regUpdateValid),
        .commit_dest   (regUpdateDest),
        .commit_rob_id (regUpdateRobId),
        .commit_value  (regValue),
        .rob_ready     (rs1Ready),
        .rob_value     (rs1Value),
        .dep           (rs1Dep),
        .result        (op1)
    );

    register_read_port u_read2 (
        .rs            (iuRs2),
        .reg_busy      (busy[iuRs2]),
        .reg_tag       (tags[iuRs2]),
        .reg_value     (values[iuRs2]),
        .commit_valid  (regUpdateValid),
        .commit_dest   (regUpdateDest),
        .commit_rob_id (regUpdateRobId),
        .commit_value  (regValue),
        .rob_ready     (rs2Ready),
        .rob_value     (rs2Value),
        .dep           (rs2Dep),
        .result        (op2)
    );

    assign iuRs1Valid = op1.valid;
    assign iuRs1Value = op1.value;
    assign iuRs1Tag   = op1.tag;
    assign iuRs2Valid = op2.valid;
    assign iuRs2Value = op2.value;
    assign iuRs2Tag   = op2.tag;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, async reset sequence, then random
// stimulus compared against an array-based reference model.
// Outputs are sampled 3 time units after inputs change, well away from clock edges.
module tb_register_file;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        clear;
    logic        regUpdateValid;
    logic [4:0]  regUpdateDest;
    logic [31:0] regValue;
    logic [3:0]  regUpdateRobId;
    logic [3:0]  rs1Dep;
    logic        rs1Ready;
    logic [31:0] rs1Value;
    logic [3:0]  rs2Dep;
    logic        rs2Ready;
    logic [31:0] rs2Value;
    logic [4:0]  iuRs1;
    logic [4:0]  iuRs2;
    logic        iuRs1Valid;
    logic [31:0] iuRs1Value;
    logic [3:0]  iuRs1Tag;
    logic        iuRs2Valid;
    logic [31:0] iuRs2Value;
    logic [3:0]  iuRs2Tag;
    logic        renameValid;
    logic [4:0]  renameDest;
    logic [3:0]  renameRobId;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clockIn = ~clockIn;

    register_file dut (
        .clockIn        (clockIn),
        .resetIn        (resetIn),
        .clear          (clear),
        .regUpdateValid (regUpdateValid),
        .regUpdateDest  (regUpdateDest),
        .regValue       (regValue),
        .regUpdateRobId (regUpdateRobId),
        .rs1Dep         (rs1Dep),
        .rs1Ready       (rs1Ready),
        .rs1Value       (rs1Value),
        .rs2Dep         (rs2Dep),
        .rs2Ready       (rs2Ready),
        .rs2Value       (rs2Value),
        .iuRs1          (iuRs1),
        .iuRs2          (iuRs2),
        .iuRs1Valid     (iuRs1Valid),
        .iuRs1Value     (iuRs1Value),
        .iuRs1Tag       (iuRs1Tag),
        .iuRs2Valid     (iuRs2Valid),
        .iuRs2Value     (iuRs2Value),
        .iuRs2Tag       (iuRs2Tag),
        .renameValid    (renameValid),
        .renameDest     (renameDest),
        .renameRobId    (renameRobId)
    );

    // Reference model: plain arrays of architectural state.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    typedef struct {
        logic        cv;  logic [4:0] cd;  logic [31:0] cval; logic [3:0] cid;
        logic        rnv; logic [4:0] rnd; logic [3:0]  rnid;
        logic        clr;
        logic [4:0]  a1;  logic r1y; logic [31:0] r1v;
        logic [4:0]  a2;  logic r2y; logic [31:0] r2v;
        logic        e1v; logic [31:0] e1val; logic [3:0] e1tag; logic [3:0] e1dep;
        logic        e2v; logic [31:0] e2val; logic [3:0] e2tag; logic [3:0] e2dep;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
        end
    endtask

    // Applies the current inputs to the model as the coming clock edge will.
    task automatic model_update();
        if (regUpdateValid && regUpdateDest != 0) begin
            m_val[regUpdateDest] = regValue;
            if (m_busy[regUpdateDest] && m_tag[regUpdateDest] == regUpdateRobId)
                m_busy[regUpdateDest] = 1'b0;
        end
        if (clear) begin
            for (int i = 0; i < 32; i++) begin
                m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (renameValid && renameDest != 0) begin
            m_busy[renameDest] = 1'b1;
            m_tag[renameDest]  = renameRobId;
        end
    endtask

    function automatic void exp_read(input logic [4:0] rs, input logic ry, input logic [31:0] rv,
                                     output logic v, output logic [31:0] val,
                                     output logic [3:0] tag, output logic [3:0] dep);
        dep = m_busy[rs] ? m_tag[rs] : 4'd0;
        v = 1'b1; val = '0; tag = '0;
        if (rs == 0) val = '0;
        else if (!m_busy[rs]) val = m_val[rs];
        else if (regUpdateValid && regUpdateDest == rs && regUpdateRobId == m_tag[rs]) val = regValue;
        else if (ry) val = rv;
        else begin v = 1'b0; tag = m_tag[rs]; end
    endfunction

    task automatic drive_idle();
        clear = 0; regUpdateValid = 0; regUpdateDest = 0; regValue = 0; regUpdateRobId = 0;
        rs1Ready = 0; rs1Value = 0; rs2Ready = 0; rs2Value = 0; iuRs1 = 0; iuRs2 = 0;
        renameValid = 0; renameDest = 0; renameRobId = 0;
    endtask

    task automatic clock_step();
        model_update();
        @(posedge clockIn);
        #1;
    endtask

    task automatic check_ports(input string tagname, input logic v1, input logic [31:0] val1,
                               input logic [3:0] t1, input logic [3:0] d1, input logic v2,
                               input logic [31:0] val2, input logic [3:0] t2, input logic [3:0] d2);
        check({tagname, " rs1 valid"}, 32'(iuRs1Valid), 32'(v1));
        check({tagname, " rs1 value"}, iuRs1Value, val1);
        check({tagname, " rs1 tag"},   32'(iuRs1Tag), 32'(t1));
        check({tagname, " rs1Dep"},    32'(rs1Dep), 32'(d1));
        check({tagname, " rs2 valid"}, 32'(iuRs2Valid), 32'(v2));
        check({tagname, " rs2 value"}, iuRs2Value, val2);
        check({tagname, " rs2 tag"},   32'(iuRs2Tag), 32'(t2));
        check({tagname, " rs2Dep"},    32'(rs2Dep), 32'(d2));
    endtask

    initial begin
        logic        v1, v2;
        logic [31:0] x1, x2;
        logic [3:0]  t1, t2, d1, d2;
        logic [4:0]  a;

        //            cv cd cval          cid  rnv rnd rnid clr a1 r1y r1v     a2 r2y r2v            e1: v val tag dep         e2: v val tag dep
        vecs[0]  = '{0, 0, 0,            0,   1, 3, 7,  0,  5, 0, 0,       3, 0, 0,            1, 0,            0, 0,  1, 0,            0, 0};
        vecs[1]  = '{0, 0, 0,            0,   0, 0, 0,  0,  3, 0, 0,       3, 1, 32'hABCD,     0, 0,            7, 7,  1, 32'hABCD,     0, 7};
        vecs[2]  = '{1, 3, 32'h55,       7,   0, 0, 0,  0,  3, 0, 0,       3, 1, 32'h99,       1, 32'h55,       0, 7,  1, 32'h55,       0, 7};
        vecs[3]  = '{0, 0, 0,            0,   1, 3, 2,  0,  3, 0, 0,       4, 0, 0,            1, 32'h55,       0, 0,  1, 0,            0, 0};
        vecs[4]  = '{1, 3, 32'h11,       9,   1, 4, 1,  0,  3, 0, 0,       3, 1, 32'h77,       0, 0,            2, 2,  1, 32'h77,       0, 2};
        vecs[5]  = '{1, 4, 32'h44,       1,   1, 4, 5,  0,  3, 0, 0,       4, 0, 0,            0, 0,            2, 2,  1, 32'h44,       0, 1};
        vecs[6]  = '{0, 0, 0,            0,   1, 1, 3,  0,  4, 0, 0,       3, 0, 0,            0, 0,            5, 5,  0, 0,            2, 2};
        vecs[7]  = '{0, 0, 0,            0,   1, 2, 4,  0,  1, 0, 0,       0, 0, 0,            0, 0,            3, 3,  1, 0,            0, 0};
        vecs[8]  = '{1, 3, 32'h33,       2,   1, 5, 6,  1,  2, 0, 0,       3, 0, 0,            0, 0,            4, 4,  1, 32'h33,       0, 2};
        vecs[9]  = '{1, 0, 32'hDEAD,     0,   1, 0, 5,  0,  5, 0, 0,       3, 0, 0,            1, 0,            0, 0,  1, 32'h33,       0, 0};
        vecs[10] = '{0, 0, 0,            0,   0, 0, 0,  0,  0, 0, 0,       4, 0, 0,            1, 0,            0, 0,  1, 32'h44,       0, 0};
        vecs[11] = '{0, 0, 0,            0,   0, 0, 0,  0,  1, 0, 0,       2, 1, 32'hBEEF,     1, 0,            0, 0,  1, 0,            0, 0};

        drive_idle();
        model_reset();
        resetIn = 1'b1;
        repeat (2) @(posedge clockIn);
        #1;
        resetIn = 1'b0;

        // Directed table: drive one cycle of inputs, check combinational reads, clock.
        for (int i = 0; i < 12; i++) begin
            regUpdateValid = vecs[i].cv;  regUpdateDest = vecs[i].cd;
            regValue = vecs[i].cval;      regUpdateRobId = vecs[i].cid;
            renameValid = vecs[i].rnv;    renameDest = vecs[i].rnd; renameRobId = vecs[i].rnid;
            clear = vecs[i].clr;
            iuRs1 = vecs[i].a1; rs1Ready = vecs[i].r1y; rs1Value = vecs[i].r1v;
            iuRs2 = vecs[i].a2; rs2Ready = vecs[i].r2y; rs2Value = vecs[i].r2v;
            #3;
            check_ports($sformatf("vec%0d", i), vecs[i].e1v, vecs[i].e1val, vecs[i].e1tag, vecs[i].e1dep,
                        vecs[i].e2v, vecs[i].e2val, vecs[i].e2tag, vecs[i].e2dep);
            clock_step();
        end

        // Async reset mid-cycle: rename x7, then pulse reset between edges.
        drive_idle();
        renameValid = 1; renameDest = 7; renameRobId = 9;
        clock_step();
        drive_idle();
        iuRs1 = 7; iuRs2 = 4;
        #2;
        check_ports("pre_reset", 1'b0, 32'h0, 4'd9, 4'd9, 1'b1, 32'h44, 4'd0, 4'd0);
        resetIn = 1'b1;
        #1;
        check_ports("async_reset", 1'b1, 32'h0, 4'd0, 4'd0, 1'b1, 32'h0, 4'd0, 4'd0);
        model_reset();
        resetIn = 1'b0;
        @(posedge clockIn);
        #1;

        // Random stimulus against the reference model; small address range forces collisions.
        for (int n = 0; n < 1500; n++) begin
            a = 5'($urandom_range(0, 7));
            regUpdateValid = 1'($urandom_range(0, 1));
            regUpdateDest  = a;
            regValue       = $urandom;
            regUpdateRobId = ($urandom_range(0, 1) == 1) ? m_tag[a] : 4'($urandom_range(0, 15));
            renameValid    = 1'($urandom_range(0, 1));
            renameDest     = 5'($urandom_range(0, 7));
            renameRobId    = 4'($urandom_range(0, 15));
            clear          = ($urandom_range(0, 15) == 0);
            iuRs1    = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 7));
            iuRs2    = 5'($urandom_range(0, 7));
            rs1Ready = 1'($urandom_range(0, 1)); rs1Value = $urandom;
            rs2Ready = 1'($urandom_range(0, 1)); rs2Value = $urandom;
            #3;
            exp_read(iuRs1, rs1Ready, rs1Value, v1, x1, t1, d1);
            exp_read(iuRs2, rs2Ready, rs2Value, v2, x2, t2, d2);
            check_ports($sformatf("rand%0d", n), v1, x1, t1, d1, v2, x2, t2, d2);
            clock_step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
